// File: rtl/up_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : up_param_pkg
//  Purpose  : Shared definitions for the parametrised nibble core:
//             opcode encodings, control-state encoding, opcode width.
//  Revision : 1.0  initial release
// ============================================================================
package up_param_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_LIT  = 4'h1;
    localparam logic [OP_W-1:0] OP_IN   = 4'h2;
    localparam logic [OP_W-1:0] OP_OUT  = 4'h3;
    localparam logic [OP_W-1:0] OP_LD   = 4'h4;
    localparam logic [OP_W-1:0] OP_ST   = 4'h5;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h6;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h7;
    localparam logic [OP_W-1:0] OP_NAND = 4'h8;
    localparam logic [OP_W-1:0] OP_CMP  = 4'h9;
    localparam logic [OP_W-1:0] OP_JMP  = 4'hA;
    localparam logic [OP_W-1:0] OP_JC   = 4'hB;
    localparam logic [OP_W-1:0] OP_JNC  = 4'hC;
    localparam logic [OP_W-1:0] OP_JZ   = 4'hD;
    localparam logic [OP_W-1:0] OP_CALL = 4'hE;
    localparam logic [OP_W-1:0] OP_RET  = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/up_call_stack.sv
`default_nettype none
// ============================================================================
//  Module   : up_call_stack
//  Purpose  : Return-address LIFO for CALL/RET. Pointer-based, no wrap-around;
//             push when full and pop when empty are ignored.
//  Ports    : clk, rst_n (async, active low)
//             push_i, pop_i   - stack operations (push has priority)
//             data_i          - address to push
//             data_o          - current top of stack ('0 when empty)
//             full_o, empty_o - occupancy status
//  Revision : 1.0  initial release
// ============================================================================
module up_call_stack #(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] data_i,
    output logic [ADDR_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);
    import up_param_pkg::*;

    // Counter holds the number of valid entries, so it needs to reach STACK_DEPTH.
    localparam int PTR_W = $clog2(STACK_DEPTH + 1);

    logic [PTR_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];

    assign full_o  = (cnt_q == PTR_W'(STACK_DEPTH));
    assign empty_o = (cnt_q == '0);

    // Top of stack is the entry just below the count.
    always_comb begin
        data_o = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (cnt_q == PTR_W'(i + 1)) begin
                data_o = mem_q[i];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !full_o) begin
            cnt_d = cnt_q + PTR_W'(1);
        end else if (pop_i && !empty_o) begin
            cnt_d = cnt_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (push_i && !full_o && (cnt_q == PTR_W'(i))) begin
                    mem_q[i] <= data_i;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/up_param_core.sv
`default_nettype none
// ============================================================================
//  Module   : up_param_core
//  Purpose  : Parametrised two-phase (fetch/execute) accumulator core with
//             C/Z flags, pushbutton input, output register and an optional
//             hardware call/return stack with sticky fault detection.
//  Macro    : UP_STACK_EN - when defined, CALL/RET use up_call_stack and stack
//             errors enter the FAULT state; otherwise CALL/RET act as NOP and
//             fault_o is tied low.
//  Ports    : clk, rst_n (async, active low)
//             pushbuttons_i   - read by IN
//             program_word_i  - {opcode, operand} = ROM[pc_o]
//             ram_rdata_i     - RAM[ram_addr_o]
//             pc_o, phase_o, instr_o, oprnd_o, accu_o, ff_out_o,
//             c_flag_o, z_flag_o, fault_o - debug observables
//             ram_addr_o, ram_wdata_o, ram_we_o - data RAM write port
//  Revision : 1.0  initial release
// ============================================================================
module up_param_core
    import up_param_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_W-1:0]      pushbuttons_i,
    input  logic [OP_W+ADDR_W-1:0] program_word_i,
    input  logic [DATA_W-1:0]      ram_rdata_i,
    output logic [ADDR_W-1:0]      pc_o,
    output logic [ADDR_W-1:0]      ram_addr_o,
    output logic [DATA_W-1:0]      ram_wdata_o,
    output logic                   ram_we_o,
    output logic                   phase_o,
    output logic [OP_W-1:0]        instr_o,
    output logic [ADDR_W-1:0]      oprnd_o,
    output logic [DATA_W-1:0]      accu_o,
    output logic [DATA_W-1:0]      ff_out_o,
    output logic                   c_flag_o,
    output logic                   z_flag_o,
    output logic                   fault_o
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [OP_W-1:0]     instr_q, instr_d;
    logic [ADDR_W-1:0]   oprnd_q, oprnd_d;
    logic [DATA_W-1:0]   accu_q, accu_d;
    logic [DATA_W-1:0]   ff_q, ff_d;
    logic                c_q, c_d;
    logic                z_q, z_d;

    logic [ADDR_W-1:0]   pc_plus1;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W:0]     add_ext;
    logic [DATA_W:0]     sub_ext;
    logic [DATA_W-1:0]   nand_res;

    assign pc_plus1 = pc_q + ADDR_W'(1);
    assign imm      = oprnd_q[DATA_W-1:0];
    assign add_ext  = {1'b0, accu_q} + {1'b0, imm};
    // MSB of the extended difference is the borrow; carry means "no borrow".
    assign sub_ext  = {1'b0, accu_q} - {1'b0, imm};
    assign nand_res = ~(accu_q & imm);

`ifdef UP_STACK_EN
    logic              stk_push;
    logic              stk_pop;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_full;
    logic              stk_empty;

    up_call_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_call_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .data_i  (pc_plus1),
        .data_o  (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );
`else
    // Depth has no meaning without the stack; keep the parameter referenced.
    if (STACK_DEPTH < 1) begin : g_depth_unused
    end
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        oprnd_d = oprnd_q;
        accu_d  = accu_q;
        ff_d    = ff_q;
        c_d     = c_q;
        z_d     = z_q;
`ifdef UP_STACK_EN
        stk_push = 1'b0;
        stk_pop  = 1'b0;
`endif
        case (state_q)
            ST_FETCH: begin
                instr_d = program_word_i[OP_W+ADDR_W-1 -: OP_W];
                oprnd_d = program_word_i[ADDR_W-1:0];
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_plus1;
                case (instr_q)
                    OP_LIT:  accu_d = imm;
                    OP_IN:   accu_d = pushbuttons_i;
                    OP_OUT:  ff_d   = accu_q;
                    OP_LD:   accu_d = ram_rdata_i;
                    OP_ADD: begin
                        accu_d = add_ext[DATA_W-1:0];
                        c_d    = add_ext[DATA_W];
                        z_d    = (add_ext[DATA_W-1:0] == '0);
                    end
                    OP_SUB: begin
                        accu_d = sub_ext[DATA_W-1:0];
                        c_d    = ~sub_ext[DATA_W];
                        z_d    = (sub_ext[DATA_W-1:0] == '0);
                    end
                    OP_NAND: begin
                        accu_d = nand_res;
                        c_d    = 1'b0;
                        z_d    = (nand_res == '0);
                    end
                    OP_CMP: begin
                        c_d = ~sub_ext[DATA_W];
                        z_d = (sub_ext[DATA_W-1:0] == '0);
                    end
                    OP_JMP:  pc_d = oprnd_q;
                    OP_JC:   if (c_q)  pc_d = oprnd_q;
                    OP_JNC:  if (!c_q) pc_d = oprnd_q;
                    OP_JZ:   if (z_q)  pc_d = oprnd_q;
`ifdef UP_STACK_EN
                    OP_CALL: begin
                        if (stk_full) begin
                            pc_d    = pc_q;
                            state_d = ST_FAULT;
                        end else begin
                            stk_push = 1'b1;
                            pc_d     = oprnd_q;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            pc_d    = pc_q;
                            state_d = ST_FAULT;
                        end else begin
                            stk_pop = 1'b1;
                            pc_d    = stk_top;
                        end
                    end
`endif
                    default: ;
                endcase
            end
            ST_FAULT: ;
            default:  state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            instr_q <= '0;
            oprnd_q <= '0;
            accu_q  <= '0;
            ff_q    <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            oprnd_q <= oprnd_d;
            accu_q  <= accu_d;
            ff_q    <= ff_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    // Decoded from the state register so reset removes the strobe immediately.
    assign ram_we_o    = (state_q == ST_EXEC) && (instr_q == OP_ST);
    assign phase_o     = (state_q != ST_FETCH);
    assign pc_o        = pc_q;
    assign ram_addr_o  = oprnd_q;
    assign ram_wdata_o = accu_q;
    assign instr_o     = instr_q;
    assign oprnd_o     = oprnd_q;
    assign accu_o      = accu_q;
    assign ff_out_o    = ff_q;
    assign c_flag_o    = c_q;
    assign z_flag_o    = z_q;
`ifdef UP_STACK_EN
    assign fault_o     = (state_q == ST_FAULT);
`else
    assign fault_o     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_up_param_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_up_param_core
//  Purpose  : Self-checking bench for up_param_core: instruction-level model,
//             per-cycle comparison, directed programs and random programs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_up_param_core;
    localparam int DATA_W      = 4;
    localparam int ADDR_W      = 12;
    localparam int STACK_DEPTH = 4;
    localparam int MASK        = (1 << DATA_W) - 1;
    localparam int AMASK       = (1 << ADDR_W) - 1;
`ifdef UP_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] pushbuttons = '0;
    logic [15:0]       program_word;
    logic [DATA_W-1:0] ram_rdata;
    logic [ADDR_W-1:0] pc, ram_addr, oprnd;
    logic [DATA_W-1:0] ram_wdata, accu, ff_out;
    logic [3:0]        instr;
    logic              ram_we, phase, c_flag, z_flag, fault;

    logic [15:0]       rom [4096];
    logic [DATA_W-1:0] ram [4096];

    assign program_word = rom[pc];
    assign ram_rdata    = ram[ram_addr];

    always #5 clk = ~clk;

    up_param_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .pushbuttons_i(pushbuttons),
        .program_word_i(program_word), .ram_rdata_i(ram_rdata),
        .pc_o(pc), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_we_o(ram_we),
        .phase_o(phase), .instr_o(instr), .oprnd_o(oprnd), .accu_o(accu),
        .ff_out_o(ff_out), .c_flag_o(c_flag), .z_flag_o(z_flag), .fault_o(fault)
    );

    // Data RAM: written on the closing edge of a cycle with the strobe high.
    always @(posedge clk) begin
        if (ram_we === 1'b1) ram[ram_addr] = ram_wdata;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- instruction-level reference model ----------------
    bit                m_active = 1'b0;
    int                m_pc, m_phase, m_instr, m_oprnd, m_accu, m_ff, m_c, m_z, m_fault;
    int                m_stack [$];
    logic [DATA_W-1:0] m_ram [4096];

    task automatic model_reset();
        m_pc = 0; m_phase = 0; m_instr = 0; m_oprnd = 0; m_accu = 0;
        m_ff = 0; m_c = 0; m_z = 0; m_fault = 0;
        m_stack.delete();
    endtask

    task automatic model_exec();
        int imm, npc, r;
        imm = m_oprnd & MASK;
        npc = (m_pc + 1) & AMASK;
        case (m_instr)
            1:  m_accu = imm;
            2:  m_accu = int'(pushbuttons);
            3:  m_ff = m_accu;
            4:  m_accu = int'(m_ram[m_oprnd[11:0]]);
            5:  m_ram[m_oprnd[11:0]] = m_accu[DATA_W-1:0];
            6:  begin r = m_accu + imm; m_c = (r > MASK) ? 1 : 0;
                      m_accu = r & MASK; m_z = (m_accu == 0) ? 1 : 0; end
            7:  begin m_c = (m_accu >= imm) ? 1 : 0;
                      m_accu = (m_accu - imm) & MASK; m_z = (m_accu == 0) ? 1 : 0; end
            8:  begin m_accu = ~(m_accu & imm) & MASK; m_c = 0;
                      m_z = (m_accu == 0) ? 1 : 0; end
            9:  begin m_c = (m_accu >= imm) ? 1 : 0;
                      m_z = (((m_accu - imm) & MASK) == 0) ? 1 : 0; end
            10: npc = m_oprnd;
            11: if (m_c != 0) npc = m_oprnd;
            12: if (m_c == 0) npc = m_oprnd;
            13: if (m_z != 0) npc = m_oprnd;
            14: if (STACK_EN) begin
                    if (m_stack.size() == STACK_DEPTH) m_fault = 1;
                    else begin m_stack.push_back(npc); npc = m_oprnd; end
                end
            15: if (STACK_EN) begin
                    if (m_stack.size() == 0) m_fault = 1;
                    else npc = m_stack.pop_back();
                end
            default: ;
        endcase
        if (m_fault == 0) begin
            m_pc = npc;
            m_phase = 0;
        end
    endtask

    // Per-cycle comparison, mid-cycle, then advance the model by one cycle.
    always @(negedge clk) begin
        logic [15:0] w;
        if (m_active) begin
            check("pc",        32'(pc),        m_pc);
            check("phase",     32'(phase),     (m_fault != 0) ? 1 : m_phase);
            check("instr",     32'(instr),     m_instr);
            check("oprnd",     32'(oprnd),     m_oprnd);
            check("accu",      32'(accu),      m_accu);
            check("ff_out",    32'(ff_out),    m_ff);
            check("c_flag",    32'(c_flag),    m_c);
            check("z_flag",    32'(z_flag),    m_z);
            check("fault",     32'(fault),     m_fault);
            check("ram_addr",  32'(ram_addr),  m_oprnd);
            check("ram_wdata", 32'(ram_wdata), m_accu);
            check("ram_we",    32'(ram_we),
                  (m_fault == 0 && m_phase == 1 && m_instr == 5) ? 1 : 0);
            if (m_fault == 0) begin
                if (m_phase == 0) begin
                    w = rom[m_pc[11:0]];
                    m_instr = int'(w[15:12]);
                    m_oprnd = int'(w[11:0]);
                    m_phase = 1;
                end else begin
                    model_exec();
                end
            end
        end
    end

    // Write-strobe monitor for the store test.
    int                we_cnt = 0;
    logic [ADDR_W-1:0] we_addr;
    logic [DATA_W-1:0] we_data;
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            we_cnt  = we_cnt + 1;
            we_addr = ram_addr;
            we_data = ram_wdata;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [15:0] enc(input int op, input int opr);
        logic [15:0] v;
        v = {op[3:0], opr[11:0]};
        return v;
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 16'h0000;
    endtask

    task automatic apply_reset();
        m_active = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_pc",    32'(pc),     0);
        check("rst_phase", 32'(phase),  0);
        check("rst_instr", 32'(instr),  0);
        check("rst_oprnd", 32'(oprnd),  0);
        check("rst_accu",  32'(accu),   0);
        check("rst_ff",    32'(ff_out), 0);
        check("rst_c",     32'(c_flag), 0);
        check("rst_z",     32'(z_flag), 0);
        check("rst_fault", 32'(fault),  0);
        check("rst_we",    32'(ram_we), 0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        m_active = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]   = DATA_W'($urandom);
            m_ram[i] = ram[i];
        end
        clear_rom();
        cycles(2);
        apply_reset();

        // LIT 5, ADD 0xC: wraps to 1 with carry; phase alternates.
        clear_rom();
        rom[0] = enc(1, 5);
        rom[1] = enc(6, 'hC);
        release_reset();
        check("t1_phase0", 32'(phase), 0);
        cycles(1); check("t1_phase1", 32'(phase), 1);
        cycles(1); check("t1_phase2", 32'(phase), 0); check("t1_pc1", 32'(pc), 1);
        cycles(1); check("t1_phase3", 32'(phase), 1);
        cycles(1);
        check("t1_pc2",  32'(pc),     2);
        check("t1_accu", 32'(accu),   1);
        check("t1_c",    32'(c_flag), 1);
        check("t1_z",    32'(z_flag), 0);

        // LIT 3, SUB 3, JZ 0x020 taken; then JNC not taken.
        apply_reset();
        clear_rom();
        rom[0]     = enc(1, 3);
        rom[1]     = enc(7, 3);
        rom[2]     = enc(13, 'h020);
        rom['h020] = enc(12, 'h100);
        release_reset();
        cycles(6);
        check("t2_pc_jz", 32'(pc),     'h020);
        check("t2_z",     32'(z_flag), 1);
        check("t2_c",     32'(c_flag), 1);
        cycles(2);
        check("t2_pc_jnc", 32'(pc), 'h021);

        // LIT 9, ST 0x010, LIT 0, LD 0x010, OUT.
        apply_reset();
        clear_rom();
        rom[0] = enc(1, 9);
        rom[1] = enc(5, 'h010);
        rom[2] = enc(1, 0);
        rom[3] = enc(4, 'h010);
        rom[4] = enc(3, 0);
        we_cnt = 0;
        release_reset();
        cycles(10);
        check("t3_we_cnt",  32'(we_cnt),     1);
        check("t3_we_addr", 32'(we_addr),    'h010);
        check("t3_we_data", 32'(we_data),    9);
        check("t3_ram",     32'(ram['h010]), 9);
        check("t3_ff",      32'(ff_out),     9);

        // CALL 0x040 at 0x005, RET at 0x040.
        apply_reset();
        clear_rom();
        rom[5]     = enc(14, 'h040);
        rom['h040] = enc(15, 0);
        release_reset();
        cycles(12);
        check("t4_pc_call", 32'(pc), STACK_EN ? 'h040 : 'h006);
        cycles(2);
        check("t4_pc_ret",  32'(pc), STACK_EN ? 'h006 : 'h007);
        check("t4_fault",   32'(fault), 0);

        // STACK_DEPTH+1 nested CALLs: the last overflows.
        apply_reset();
        clear_rom();
        for (int k = 0; k <= STACK_DEPTH; k++) rom[k] = enc(14, k + 1);
        release_reset();
        cycles(2 * (STACK_DEPTH + 1));
        check("t5_fault", 32'(fault), STACK_EN ? 1 : 0);
        check("t5_pc",    32'(pc),    STACK_EN ? STACK_DEPTH : STACK_DEPTH + 1);
        cycles(4);
        check("t5_pc_hold",    32'(pc),    STACK_EN ? STACK_DEPTH : STACK_DEPTH + 3);
        check("t5_phase_hold", 32'(phase), STACK_EN ? 1 : 0);
        apply_reset();

        // Reset asserted in the middle of a store's execute cycle.
        clear_rom();
        rom[0] = enc(1, 7);
        rom[1] = enc(5, 'h020);
        ram['h020]   = 4'h2;
        m_ram['h020] = 4'h2;
        release_reset();
        cycles(3);
        check("t6_we_before", 32'(ram_we), 1);
        apply_reset();
        cycles(3);
        check("t6_ram_kept", 32'(ram['h020]), 2);

        // Random programs, each started from reset.
        for (int seg = 0; seg < 20; seg++) begin
            apply_reset();
            for (int i = 0; i < 4096; i++) begin
                int op;
                op = $urandom_range(0, 15);
                if (op >= 14 && $urandom_range(0, 3) != 0) op = $urandom_range(0, 13);
                rom[i] = {op[3:0], 12'($urandom)};
            end
            release_reset();
            repeat (300) begin
                @(posedge clk);
                #1;
                pushbuttons = DATA_W'($urandom);
            end
        end

        m_active = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
